bot_pair_feeder: RTL



---
 rtl/bot_pair_feeder.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/bot_pair_feeder.sv
// Upstream feeder for inputModule4: takes (A, C) bot pairs, derives the swapped
// twins B and D, flags which of the four lie below the current top, and emits them in batch order.
module bot_pair_feeder #(
   parameter int INDEX_WIDTH = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [127:0]           top,
   input  logic                   start,
   input  logic [INDEX_WIDTH:0]   batchSize,
   input  logic [127:0]           inBotA,
   input  logic [127:0]           inBotC,
   input  logic                   inValid,
   output logic                   inReady,
   output logic [127:0]           botA,
   output logic [127:0]           botC,
   output logic [INDEX_WIDTH-1:0] botIndex,
   output logic                   validBotA,
   output logic                   validBotB,
   output logic                   validBotC,
   output logic                   validBotD,
   input  logic                   almostFull,
   output logic                   busy,
   output logic                   done,
   output logic [INDEX_WIDTH+2:0] validCount
);

   localparam logic [INDEX_WIDTH:0]   MAX_PAIRS = {1'b1, {INDEX_WIDTH{1'b0}}};
   localparam logic [INDEX_WIDTH:0]   REM_ONE   = 1;
   localparam logic [INDEX_WIDTH-1:0] IDX_ONE   = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // varSwap(5,6) on a 7-variable truth table exchanges the two middle 32-bit words.
   function automatic logic [127:0] swap56(input logic [127:0] x);
      swap56 = {x[127:96], x[63:32], x[95:64], x[31:0]};
   endfunction

   function automatic logic is_sub(input logic [127:0] x, input logic [127:0] t);
      is_sub = ((x & ~t) == 128'b0);
   endfunction

   function automatic logic [INDEX_WIDTH+2:0] pop4(input logic [3:0] f);
      pop4 = '0;
      for (int i = 0; i < 4; i++) begin
         pop4 = pop4 + {{(INDEX_WIDTH+2){1'b0}}, f[i]};
      end
   endfunction

   state_t                   state_q, state_d;
   logic [127:0]             top_q, top_d;
   logic [INDEX_WIDTH:0]     remaining_q, remaining_d;
   logic [INDEX_WIDTH-1:0]   pair_cnt_q, pair_cnt_d;
   logic [INDEX_WIDTH+2:0]   count_q, count_d;

   logic                     s1_valid_q, s1_valid_d;
   logic [127:0]             s1_a_q, s1_a_d;
   logic [127:0]             s1_c_q, s1_c_d;
   logic [INDEX_WIDTH-1:0]   s1_idx_q, s1_idx_d;
   logic [3:0]               s1_flags_q, s1_flags_d;

   logic                     s2_valid_q, s2_valid_d;
   logic [127:0]             s2_a_q, s2_a_d;
   logic [127:0]             s2_c_q, s2_c_d;
   logic [INDEX_WIDTH-1:0]   s2_idx_q, s2_idx_d;
   logic [3:0]               s2_flags_q, s2_flags_d;

   logic [INDEX_WIDTH:0]     size_clamped;
   logic                     start_ok;
   logic                     accept;
   logic [3:0]               in_flags;

   assign size_clamped = (batchSize > MAX_PAIRS) ? MAX_PAIRS : batchSize;
   assign accept       = inReady & inValid;
   assign in_flags     = {is_sub(inBotA, top_q), is_sub(swap56(inBotA), top_q),
                          is_sub(inBotC, top_q), is_sub(swap56(inBotC), top_q)};

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      inReady  = 1'b0;
      start_ok = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               start_ok = 1'b1;
               state_d  = (size_clamped == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            inReady = !almostFull && (remaining_q != '0);
            if (inReady && inValid && (remaining_q == REM_ONE)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!s1_valid_q && !s2_valid_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      top_d       = top_q;
      remaining_d = remaining_q;
      pair_cnt_d  = pair_cnt_q;
      count_d     = count_q;

      s1_valid_d  = accept;
      s1_a_d      = s1_a_q;
      s1_c_d      = s1_c_q;
      s1_idx_d    = s1_idx_q;
      s1_flags_d  = s1_flags_q;

      s2_valid_d  = s1_valid_q;
      s2_a_d      = s2_a_q;
      s2_c_d      = s2_c_q;
      s2_idx_d    = s2_idx_q;
      s2_flags_d  = 4'b0000;

      if (accept) begin
         s1_a_d      = inBotA;
         s1_c_d      = inBotC;
         s1_idx_d    = pair_cnt_q;
         s1_flags_d  = in_flags;
         pair_cnt_d  = pair_cnt_q + IDX_ONE;
         remaining_d = remaining_q - REM_ONE;
      end

      // The count moves on the same edge the flags reach the outputs.
      if (s1_valid_q) begin
         s2_a_d     = s1_a_q;
         s2_c_d     = s1_c_q;
         s2_idx_d   = s1_idx_q;
         s2_flags_d = s1_flags_q;
         count_d    = count_q + pop4(s1_flags_q);
      end

      if (start_ok) begin
         top_d       = top;
         remaining_d = size_clamped;
         pair_cnt_d  = '0;
         count_d     = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; all next-state values come from the _d nets.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the data registers are cleared too, because botA/botC must read zero after reset.
         state_q     <= ST_IDLE;
         top_q       <= '0;
         remaining_q <= '0;
         pair_cnt_q  <= '0;
         count_q     <= '0;
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_c_q      <= '0;
         s1_idx_q    <= '0;
         s1_flags_q  <= '0;
         s2_valid_q  <= 1'b0;
         s2_a_q      <= '0;
         s2_c_q      <= '0;
         s2_idx_q    <= '0;
         s2_flags_q  <= '0;
      end else begin
         state_q     <= state_d;
         top_q       <= top_d;
         remaining_q <= remaining_d;
         pair_cnt_q  <= pair_cnt_d;
         count_q     <= count_d;
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_c_q      <= s1_c_d;
         s1_idx_q    <= s1_idx_d;
         s1_flags_q  <= s1_flags_d;
         s2_valid_q  <= s2_valid_d;
         s2_a_q      <= s2_a_d;
         s2_c_q      <= s2_c_d;
         s2_idx_q    <= s2_idx_d;
         s2_flags_q  <= s2_flags_d;
      end
   end

   assign botA       = s2_a_q;
   assign botC       = s2_c_q;
   assign botIndex   = s2_idx_q;
   assign validBotA  = s2_flags_q[3];
   assign validBotB  = s2_flags_q[2];
   assign validBotC  = s2_flags_q[1];
   assign validBotD  = s2_flags_q[0];
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);
   assign validCount = count_q;

endmodule
